alu_mc: RTL and testbench
=========================

ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width in bits (legal 4..32).
REQ-002 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port in_valid, input, 1, request present.
REQ-005 SHALL have port in_ready, output, 1, request accepted when in_valid && in_ready at a rising edge.
REQ-006 SHALL have ports a and b, input, WIDTH each, operands (two's complement where signed).
REQ-007 SHALL have port op, input, 4, operation select: 0000 ADD, 0001 SUB, 0010 NOT a, 0011 AND, 0100 OR, 0101 XOR, 0110 LESS (signed), 0111 EQUAL, 1000 MUL; other codes illegal.
REQ-008 SHALL have port out_valid, output, 1, result and flags valid.
REQ-009 SHALL have port out_ready, input, 1, result consumed when out_valid && out_ready at a rising edge.
REQ-010 SHALL have port result, output, WIDTH, operation result.
REQ-011 SHALL have ports zero_f, over_f, cout_f, less, output, 1 each, status flags.
REQ-012 SHALL have port busy, output, 1, high while a MUL iterates.

Function
REQ-013 SHALL implement FSM states IDLE, BUSY, DONE; in_ready = IDLE || (DONE && out_ready).
REQ-014 SHALL, on accepting a non-MUL op, register result/flags and enter DONE; out_valid rises the cycle after acceptance (latency 1).
REQ-015 SHALL, on accepting MUL, capture operands, enter BUSY for exactly WIDTH cycles (busy=1), then enter DONE; latency WIDTH+1.
REQ-016 SHALL hold result, flags and out_valid stable in DONE until out_ready; DONE with out_ready and no new request returns to IDLE.
REQ-017 SHALL accept a new request in the same cycle the DONE result is consumed (back-to-back, no bubble).
REQ-018 ADD/SUB: xb = b XOR {WIDTH{sub}}; {cout_f,result} = a + xb + sub; over_f = (a[MSB]==xb[MSB]) && (a[MSB]!=result[MSB]).
REQ-019 NOT/AND/OR/XOR: bitwise result; cout_f = over_f = 0.
REQ-020 LESS: less = signed(a) < signed(b), computed via SUB as result_sub[MSB] XOR over_sub; result = zero-extended less.
REQ-021 EQUAL: result = zero-extended (a == b).
REQ-022 MUL: unsigned shift-add; result = low WIDTH bits of product; cout_f = over_f = OR of high WIDTH bits.
REQ-023 zero_f SHALL equal (result == 0) for every legal op; less SHALL be 0 for all ops except LESS.
REQ-024 Illegal op SHALL complete in latency 1 with result and all flags 0.
REQ-025 in_valid/operand changes while BUSY or DONE (in_ready=0) SHALL have no effect.

Reset
REQ-026 rst_n low SHALL immediately force IDLE, in_ready=1, out_valid=0, busy=0, result=0, all flags 0.
REQ-027 Reset during BUSY or DONE SHALL discard the in-flight operation; nothing is emitted after release.

Configuration
REQ-028 Macro ALU_MC_MUL_EN defined: MUL (1000) SHALL behave per REQ-015/022.
REQ-029 ALU_MC_MUL_EN undefined: 1000 SHALL be illegal (REQ-024), BUSY unreachable, busy tied 0, multiplier not instantiated.

Structure
REQ-030 Package alu_mc_pkg SHALL hold the op code enum, the FSM state enum, and flag-bundle struct.
REQ-031 Sub-module alu_mul_seq SHALL implement the iterative multiplier (start, done, WIDTH-parametrised), instantiated only under ALU_MC_MUL_EN.

Verification (WIDTH=8)
REQ-032 ADD a=0x7F b=0x01 -> result 0x80, over_f=1, cout_f=0, zero_f=0, out_valid one cycle after accept.
REQ-033 SUB a=0x05 b=0x05 then LESS a=0xFE b=0x01 back-to-back with out_ready=1 -> result 0x00 zero_f=1 cout_f=1; then less=1 result 0x01; no bubble.
REQ-034 MUL a=0x10 b=0x11 (macro on) -> busy 8 cycles, result 0x10, cout_f=over_f=1, out_valid at cycle 9.
REQ-035 ADD a=0x01 b=0x02 with out_ready=0 for 5 cycles -> result 0x03 held, in_ready=0, new requests ignored until consumed.
REQ-036 rst_n asserted mid-MUL (cycle 4) -> outputs zero immediately, IDLE after release, no out_valid.
REQ-037 op=1000 with macro off, and op=1111 -> latency 1, result 0x00, all flags 0.

Source files
------------

// File: rtl/alu_mc_pkg.sv
// alu_mc_pkg: op codes, FSM states and flag bundle
// shared by the multi-cycle ALU and its multiplier.
package alu_mc_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'b0000,
        OP_SUB  = 4'b0001,
        OP_NOT  = 4'b0010,
        OP_AND  = 4'b0011,
        OP_OR   = 4'b0100,
        OP_XOR  = 4'b0101,
        OP_LESS = 4'b0110,
        OP_EQ   = 4'b0111,
        OP_MUL  = 4'b1000
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    typedef struct packed {
        logic zero;
        logic over;
        logic cout;
        logic less;
    } flags_t;

endpackage

// File: rtl/alu_mul_seq.sv
// alu_mul_seq: iterative unsigned shift-add multiplier.
// One partial product per cycle; done marks the last one.
module alu_mul_seq #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               done,
    output logic [2*WIDTH-1:0] prod
);

    localparam int CW = $clog2(WIDTH);

    logic               active;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] mcand;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_nx;
    logic [WIDTH-1:0]   mplier;

    assign acc_nx = acc + (mplier[0] ? mcand : '0);
    assign done   = active && (cnt == CW'(WIDTH - 1));
    assign prod   = acc_nx;

    // load operands on start, then one shift-add step per cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active <= 1'b0;
            cnt    <= '0;
            mcand  <= '0;
            acc    <= '0;
            mplier <= '0;
        end else if (start) begin
            active <= 1'b1;
            cnt    <= '0;
            mcand  <= {{WIDTH{1'b0}}, a};
            acc    <= '0;
            mplier <= b;
        end else if (active) begin
            acc    <= acc_nx;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
            if (done) active <= 1'b0;
        end
    end

endmodule

// File: rtl/alu_mc.sv
// alu_mc: valid/ready ALU, 1-cycle ops, WIDTH-cycle MUL.
// MUL exists only when ALU_MC_MUL_EN is defined.
module alu_mc
    import alu_mc_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero_f,
    output logic             over_f,
    output logic             cout_f,
    output logic             less,
    output logic             busy
);

    state_e             state;
    state_e             state_nx;
    op_e                opc;
    logic               accept;
    logic               is_mul;
    logic               mul_done;
    logic [2*WIDTH-1:0] mul_prod;
    logic [WIDTH-1:0]   res_q;
    logic [WIDTH-1:0]   res_c;
    flags_t             flg_q;
    flags_t             flg_c;
    flags_t             mul_flg;
    logic               legal;
    logic               sub;
    logic [WIDTH-1:0]   xb;
    logic [WIDTH:0]     sum;
    logic               ovf;
    logic               lt;

    assign opc = op_e'(op);

`ifdef ALU_MC_MUL_EN
    assign is_mul = (opc == OP_MUL);
    assign busy   = (state == ST_BUSY);

    alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
        .clk   (clk),
        .rst_n (rst_n),
        .start (accept && is_mul),
        .a     (a),
        .b     (b),
        .done  (mul_done),
        .prod  (mul_prod)
    );
`else
    assign is_mul   = 1'b0;
    assign busy     = 1'b0;
    assign mul_done = 1'b0;
    assign mul_prod = '0;
`endif

    assign in_ready  = (state == ST_IDLE)
                     || (state == ST_DONE && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state == ST_DONE);

    assign result = res_q;
    assign zero_f = flg_q.zero;
    assign over_f = flg_q.over;
    assign cout_f = flg_q.cout;
    assign less   = flg_q.less;

    // shared adder: SUB and LESS use a + ~b + 1
    assign sub = (opc == OP_SUB) || (opc == OP_LESS);
    assign xb  = b ^ {WIDTH{sub}};
    assign sum = {1'b0, a} + {1'b0, xb}
               + {{WIDTH{1'b0}}, sub};
    assign ovf = (a[WIDTH-1] == xb[WIDTH-1])
              && (a[WIDTH-1] != sum[WIDTH-1]);
    assign lt  = sum[WIDTH-1] ^ ovf;

    // single-cycle result and flags for the current op
    always_comb begin
        res_c = '0;
        flg_c = '0;
        legal = 1'b1;
        case (opc)
            OP_ADD, OP_SUB: begin
                res_c      = sum[WIDTH-1:0];
                flg_c.cout = sum[WIDTH];
                flg_c.over = ovf;
            end
            OP_NOT:  res_c = ~a;
            OP_AND:  res_c = a & b;
            OP_OR:   res_c = a | b;
            OP_XOR:  res_c = a ^ b;
            OP_LESS: begin
                res_c      = {{(WIDTH-1){1'b0}}, lt};
                flg_c.less = lt;
            end
            OP_EQ:   res_c = {{(WIDTH-1){1'b0}}, a == b};
            default: legal = 1'b0;
        endcase
        flg_c.zero = legal && (res_c == '0);
    end

    // flags for a finished product
    always_comb begin
        mul_flg      = '0;
        mul_flg.zero = (mul_prod[WIDTH-1:0] == '0);
        mul_flg.over = |mul_prod[2*WIDTH-1:WIDTH];
        mul_flg.cout = |mul_prod[2*WIDTH-1:WIDTH];
    end

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nx;
    end

    // next state
    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE: begin
                if (accept)
                    state_nx = is_mul ? ST_BUSY : ST_DONE;
            end
            ST_BUSY: begin
                if (mul_done) state_nx = ST_DONE;
            end
            ST_DONE: begin
                if (accept)
                    state_nx = is_mul ? ST_BUSY : ST_DONE;
                else if (out_ready)
                    state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // result/flag registers, held until the next load
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_q <= '0;
            flg_q <= '0;
        end else if (accept && !is_mul) begin
            res_q <= res_c;
            flg_q <= flg_c;
        end else if (mul_done) begin
            res_q <= mul_prod[WIDTH-1:0];
            flg_q <= mul_flg;
        end
    end

endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: directed vector table plus handshake,
// hold, MUL and reset sequences for alu_mc at WIDTH=8.
module tb_alu_mc;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [3:0]   op;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         zero_f;
    logic         over_f;
    logic         cout_f;
    logic         less;
    logic         busy;

    int n_vec = 0;
    int n_err = 0;

    alu_mc #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero_f    (zero_f),
        .over_f    (over_f),
        .cout_f    (cout_f),
        .less      (less),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      nm;
        logic [3:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] res;
        logic [3:0] flg;
    } vec_t;

    vec_t tbl[$];

    // {out_valid, in_ready, busy, result, z, o, c, l}
    function automatic logic [38:0] obs();
        return {out_valid, in_ready, busy, 32'(result),
                zero_f, over_f, cout_f, less};
    endfunction

    function automatic logic [38:0] mk(
        logic ov, logic ir, logic bz,
        logic [31:0] res, logic [3:0] f);
        return {ov, ir, bz, res, f};
    endfunction

    task automatic chk(string nm,
                       logic [38:0] got,
                       logic [38:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h",
                     nm, got, exp);
        end
    endtask

    task automatic drive(logic v, logic [3:0] o,
                         logic [7:0] x, logic [7:0] y);
        in_valid = v;
        op       = o;
        a        = x;
        b        = y;
    endtask

    initial begin
        rst_n     = 1'b0;
        out_ready = 1'b0;
        drive(1'b0, 4'h0, 8'h00, 8'h00);

        // flags are {zero, over, cout, less}
        tbl.push_back('{"add_7f_01",  4'h0, 8'h7F, 8'h01, 8'h80, 4'b0100});
        tbl.push_back('{"add_ff_01",  4'h0, 8'hFF, 8'h01, 8'h00, 4'b1010});
        tbl.push_back('{"add_80_80",  4'h0, 8'h80, 8'h80, 8'h00, 4'b1110});
        tbl.push_back('{"sub_05_05",  4'h1, 8'h05, 8'h05, 8'h00, 4'b1010});
        tbl.push_back('{"sub_00_01",  4'h1, 8'h00, 8'h01, 8'hFF, 4'b0000});
        tbl.push_back('{"sub_80_01",  4'h1, 8'h80, 8'h01, 8'h7F, 4'b0110});
        tbl.push_back('{"not_0f",     4'h2, 8'h0F, 8'h33, 8'hF0, 4'b0000});
        tbl.push_back('{"and_f0_3c",  4'h3, 8'hF0, 8'h3C, 8'h30, 4'b0000});
        tbl.push_back('{"or_f0_0f",   4'h4, 8'hF0, 8'h0F, 8'hFF, 4'b0000});
        tbl.push_back('{"xor_aa_aa",  4'h5, 8'hAA, 8'hAA, 8'h00, 4'b1000});
        tbl.push_back('{"less_fe_01", 4'h6, 8'hFE, 8'h01, 8'h01, 4'b0001});
        tbl.push_back('{"less_01_fe", 4'h6, 8'h01, 8'hFE, 8'h00, 4'b1000});
        tbl.push_back('{"less_80_7f", 4'h6, 8'h80, 8'h7F, 8'h01, 4'b0001});
        tbl.push_back('{"eq_5a_5a",   4'h7, 8'h5A, 8'h5A, 8'h01, 4'b0000});
        tbl.push_back('{"eq_5a_5b",   4'h7, 8'h5A, 8'h5B, 8'h00, 4'b1000});
        tbl.push_back('{"illegal_f",  4'hF, 8'h12, 8'h34, 8'h00, 4'b0000});
        tbl.push_back('{"illegal_9",  4'h9, 8'hFF, 8'hFF, 8'h00, 4'b0000});
`ifndef ALU_MC_MUL_EN
        tbl.push_back('{"mul_off",    4'h8, 8'h10, 8'h11, 8'h00, 4'b0000});
`endif

        #3;
        chk("reset_state", obs(), mk(1'b0, 1'b1, 1'b0, 32'h0, 4'b0000));
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // table: accept, check one cycle later, consume
        foreach (tbl[i]) begin
            @(negedge clk);
            out_ready = 1'b0;
            drive(1'b1, tbl[i].op, tbl[i].a, tbl[i].b);
            @(negedge clk);
            drive(1'b0, 4'h0, 8'h00, 8'h00);
            chk(tbl[i].nm, obs(),
                mk(1'b1, 1'b0, 1'b0, 32'(tbl[i].res), tbl[i].flg));
            out_ready = 1'b1;
        end
        @(negedge clk);
        chk("idle_after_table", obs() & 39'h70_0000_0000,
            mk(1'b0, 1'b1, 1'b0, 32'h0, 4'b0000));

        // back-to-back SUB then LESS with no bubble
        out_ready = 1'b1;
        drive(1'b1, 4'h1, 8'h05, 8'h05);
        @(negedge clk);
        chk("b2b_sub", obs(), mk(1'b1, 1'b1, 1'b0, 32'h00, 4'b1010));
        drive(1'b1, 4'h6, 8'hFE, 8'h01);
        @(negedge clk);
        chk("b2b_less", obs(), mk(1'b1, 1'b1, 1'b0, 32'h01, 4'b0001));
        drive(1'b0, 4'h0, 8'h00, 8'h00);
        @(negedge clk);
        chk("b2b_drain", obs(), mk(1'b0, 1'b1, 1'b0, 32'h01, 4'b0001));

        // result held while out_ready low; new requests ignored
        out_ready = 1'b0;
        drive(1'b1, 4'h0, 8'h01, 8'h02);
        @(negedge clk);
        drive(1'b1, 4'h3, 8'hFF, 8'h00);
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("hold_%0d", k), obs(),
                mk(1'b1, 1'b0, 1'b0, 32'h03, 4'b0000));
            @(negedge clk);
        end
        drive(1'b0, 4'h0, 8'h00, 8'h00);
        out_ready = 1'b1;
        @(negedge clk);
        chk("hold_release", obs(), mk(1'b0, 1'b1, 1'b0, 32'h03, 4'b0000));

        // reset while a result waits in DONE
        out_ready = 1'b0;
        drive(1'b1, 4'h4, 8'h0F, 8'hA0);
        @(negedge clk);
        drive(1'b0, 4'h0, 8'h00, 8'h00);
        chk("pre_rst_done", obs(), mk(1'b1, 1'b0, 1'b0, 32'hAF, 4'b0000));
        #2 rst_n = 1'b0;
        #1;
        chk("rst_in_done", obs(), mk(1'b0, 1'b1, 1'b0, 32'h0, 4'b0000));
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("post_rst_done_%0d", k), obs(),
                mk(1'b0, 1'b1, 1'b0, 32'h0, 4'b0000));
        end

`ifdef ALU_MC_MUL_EN
        // MUL: busy for 8 cycles, result in cycle 9
        out_ready = 1'b0;
        drive(1'b1, 4'h8, 8'h10, 8'h11);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            drive(1'b1, 4'h0, 8'hFF, 8'hFF);
            chk($sformatf("mul_busy_%0d", k),
                obs() & 39'h70_0000_0000,
                mk(1'b0, 1'b0, 1'b1, 32'h0, 4'b0000));
        end
        @(negedge clk);
        drive(1'b0, 4'h0, 8'h00, 8'h00);
        chk("mul_result", obs(), mk(1'b1, 1'b0, 1'b0, 32'h10, 4'b0110));
        out_ready = 1'b1;
        @(negedge clk);
        chk("mul_drain", obs() & 39'h70_0000_0000,
            mk(1'b0, 1'b1, 1'b0, 32'h0, 4'b0000));

        // reset in cycle 4 of a MUL discards it
        out_ready = 1'b1;
        drive(1'b1, 4'h8, 8'hFF, 8'hFF);
        @(negedge clk);
        drive(1'b0, 4'h0, 8'h00, 8'h00);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("mul_pre_rst", obs() & 39'h70_0000_0000,
            mk(1'b0, 1'b0, 1'b1, 32'h0, 4'b0000));
        #2 rst_n = 1'b0;
        #1;
        chk("rst_in_busy", obs(), mk(1'b0, 1'b1, 1'b0, 32'h0, 4'b0000));
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            chk($sformatf("post_rst_busy_%0d", k), obs(),
                mk(1'b0, 1'b1, 1'b0, 32'h0, 4'b0000));
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

endmodule
